// File: rtl/data_bus_bridge.sv
// Bridges single-cycle CPU load/store strobes onto a req/ack data bus with wait states, timeout and sticky error flags.
// bus_req rises the cycle after the strobe; DATA_BUS_WBUF_EN adds a one-entry posted write buffer.
module data_bus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        err_mis_q, err_mis_d;
  logic        err_to_q, err_to_d;

  logic access, aligned, is_store;

  assign access   = cpu_rd | cpu_wr;
  assign aligned  = (cpu_addr[1:0] == 2'b00);
  assign is_store = cpu_wr & ~cpu_rd;

`ifdef DATA_BUS_WBUF_EN
  // posted_q marks a REQ that drains a buffered store the CPU has already moved past
  logic posted_q, posted_d, post_now;
  assign post_now = is_store;

  always_comb begin
    posted_d = posted_q;
    if (state_q == IDLE && access && aligned && is_store) begin
      posted_d = 1'b1;
    end else if (state_q == REQ && (bus_ack || cnt_q == CntLast)) begin
      posted_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) posted_q <= 1'b0;
    else     posted_q <= posted_d;
  end
`else
  logic posted_q, post_now;
  assign posted_q = 1'b0;
  assign post_now = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_mis_d = err_mis_q;
    err_to_d  = err_to_q;
    cpu_stall = 1'b0;
    cpu_rdata = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            cpu_stall = ~post_now;
            addr_d    = {cpu_addr[31:2], 2'b00};
            wdata_d   = cpu_wdata;
            we_d      = is_store;
            cnt_d     = 8'd0;
            state_d   = REQ;
          end else begin
            cpu_rdata = '0;
            err_mis_d = 1'b1;
          end
        end
      end
      REQ: begin
        // a posted drain only holds the CPU if it has issued another access
        cpu_stall = ~posted_q | access;
        cnt_d     = cnt_q + 8'd1;
        if (bus_ack) begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = posted_q ? IDLE : DONE;
        end else if (cnt_q == CntLast) begin
          rdata_d  = '0;
          err_to_d = 1'b1;
          state_d  = posted_q ? IDLE : DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
    end
  end

  assign bus_req      = (state_q == REQ);
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: directed cases plus randomized accesses checked against a transaction-level model.
module tb_data_bus_bridge;

  localparam int TO = 8;
`ifdef DATA_BUS_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        err_misalign, err_timeout;

  data_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_rdata = '0;
  logic        m_mis = 1'b0;
  logic        m_to = 1'b0;

  // bus responder state and observed transaction log
  int          cur_waits = 0;
  logic [31:0] cur_rdat = '0;
  int          seg_cnt = 0;
  logic        tq_we[$];
  logic [31:0] tq_addr[$];
  logic [31:0] tq_wdata[$];
  int          tq_len[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    tq_we.delete(); tq_addr.delete(); tq_wdata.delete(); tq_len.delete();
    seg_cnt = 0;
  endtask

  // one clock: answer the bus, sample at negedge, return at posedge+1
  task automatic cycle(output logic st, output logic [31:0] rd_v);
    bus_ack   = bus_req && (seg_cnt == cur_waits);
    bus_rdata = bus_ack ? cur_rdat : $urandom;
    @(negedge clk);
    if (bus_req) begin
      if (seg_cnt == 0) begin
        tq_we.push_back(bus_we); tq_addr.push_back(bus_addr); tq_wdata.push_back(bus_wdata);
      end
      seg_cnt++;
    end else if (seg_cnt != 0) begin
      tq_len.push_back(seg_cnt);
      seg_cnt = 0;
    end
    st   = cpu_stall;
    rd_v = cpu_rdata;
    @(posedge clk); #1;
  endtask

  // one CPU access; waits >= TO means the bus never acks
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rdat);
    logic        mis, posted, to, exp_we, st, fin;
    logic [31:0] rv;
    int          exp_req, exp_stall, stall_cnt, guard;
    mis       = (addr[1:0] != 2'b00);
    exp_we    = wr && !rd;
    posted    = WBUF && !mis && exp_we;
    to        = (waits >= TO);
    exp_req   = to ? TO : waits + 1;
    exp_stall = (mis || posted) ? 0 : exp_req + 1;
    if (mis) m_mis = 1'b1;
    else if (to) begin m_to = 1'b1; m_rdata = '0; end
    else if (!exp_we) m_rdata = rdat;

    clear_log();
    cur_waits = waits; cur_rdat = rdat;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    stall_cnt = 0; fin = 1'b0;
    for (int c = 0; c < 4 * TO + 16 && !fin; c++) begin
      cycle(st, rv);
      if (st) stall_cnt++;
      else begin
        fin = 1'b1;
        if (mis) check_eq("mis_rdata", rv, 32'h0);
        else if (!posted) check_eq("done_rdata", rv, m_rdata);
      end
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    guard = 0;
    while (bus_req && guard < 4 * TO) begin
      cycle(st, rv);
      guard++;
    end
    cycle(st, rv);
    bus_ack = 1'b0;

    check_eq("stall_released", 32'(fin), 32'h1);
    check_eq("stall_cycles", stall_cnt, exp_stall);
    if (mis) check_eq("mis_bus_txns", tq_we.size(), 0);
    else begin
      check_eq("bus_txns", tq_len.size(), 1);
      if (tq_len.size() > 0 && tq_we.size() > 0) begin
        check_eq("bus_addr", tq_addr.pop_front(), {addr[31:2], 2'b00});
        check_eq("bus_we", 32'(tq_we.pop_front()), 32'(exp_we));
        rv = tq_wdata.pop_front();
        if (exp_we) check_eq("bus_wdata", rv, wdata);
        check_eq("req_cycles", tq_len.pop_front(), exp_req);
      end
    end
    check_eq("rdata_hold", cpu_rdata, m_rdata);
    check_eq("err_misalign", 32'(err_misalign), 32'(m_mis));
    check_eq("err_timeout", 32'(err_timeout), 32'(m_to));
  endtask

  initial begin
    logic        st;
    logic [31:0] rv, r, a;
    int          kind, w;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_bus_req", 32'(bus_req), 0);
    check_eq("rst_bus_we", 32'(bus_we), 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_errs", {30'd0, err_misalign, err_timeout}, 0);
    check_eq("rst_stall", 32'(cpu_stall), 0);
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'h4, 32'h12345678, 0, 32'h0);
    access(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h11111111);
    access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h22222222);
    access(1'b1, 1'b1, 32'h300, 32'hAAAA5555, 2, 32'h33333333);
    access(1'b1, 1'b0, 32'h400, 32'h0, 1000, 32'h44444444);

    // ack with no request outstanding must be ignored
    bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_req", 32'(bus_req), 0);
    check_eq("late_ack_rdata", cpu_rdata, m_rdata);
    check_eq("late_ack_stall", 32'(cpu_stall), 0);
    @(posedge clk); #1;

`ifdef DATA_BUS_WBUF_EN
    begin
      int sc;
      logic fin;
      clear_log();
      cur_waits = 2; cur_rdat = 32'h5A5A0001;
      cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'hFEED0040;
      cycle(st, rv);
      check_eq("wb_post_stall", 32'(st), 0);
      cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h80;
      sc = 0; fin = 1'b0;
      for (int c = 0; c < 4 * TO + 16 && !fin; c++) begin
        cycle(st, rv);
        if (st) sc++;
        else begin fin = 1'b1; check_eq("wb_load_rdata", rv, 32'h5A5A0001); end
      end
      cpu_rd = 1'b0;
      cycle(st, rv);
      m_rdata = 32'h5A5A0001;
      check_eq("wb_load_stall", sc, 7);
      check_eq("wb_txns", tq_we.size(), 2);
      if (tq_we.size() == 2) begin
        check_eq("wb_first_we", 32'(tq_we[0]), 1);
        check_eq("wb_first_addr", tq_addr[0], 32'h40);
        check_eq("wb_first_wdata", tq_wdata[0], 32'hFEED0040);
        check_eq("wb_second_we", 32'(tq_we[1]), 0);
        check_eq("wb_second_addr", tq_addr[1], 32'h80);
      end
    end
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      r = $urandom;
      a = {r[31:2], 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 5);
      access(kind != 1, kind != 0, a, $urandom, w, $urandom);
    end

    // reset in the second REQ cycle, then a stray ack
    clear_log();
    cur_waits = 1000;
    cpu_rd = 1'b1; cpu_addr = 32'h500;
    cycle(st, rv);
    cycle(st, rv);
    rst = 1'b1;
    cycle(st, rv);
    rst = 1'b0; cpu_rd = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    m_rdata = '0; m_mis = 1'b0; m_to = 1'b0;
    @(negedge clk);
    check_eq("rstreq_bus_req", 32'(bus_req), 0);
    check_eq("rstreq_bus_addr", bus_addr, 0);
    check_eq("rstreq_bus_we", 32'(bus_we), 0);
    check_eq("rstreq_rdata", cpu_rdata, m_rdata);
    check_eq("rstreq_errs", {30'd0, err_misalign, err_timeout}, {30'd0, m_mis, m_to});
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_eq("rstack_bus_req", 32'(bus_req), 0);
    check_eq("rstack_rdata", cpu_rdata, m_rdata);
    check_eq("rstack_stall", 32'(cpu_stall), 0);
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'h600, 32'h0, 2, 32'h66666666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
